// File: rtl/dwa_selector.sv
// Unit-element selector for a thermometer DAC. It either enables elements
// statically from element 0, or rotates the start element (data-weighted
// averaging) so that mismatch between unit elements is first-order shaped.
// Every output is registered, so elem_o follows the accepted code by one cycle.
module dwa_selector #(
  parameter int unsigned OUTPUT_WIDTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,    // active-low, synchronous
  input  logic [OUTPUT_WIDTH-1:0]      code_i,
  input  logic                         valid_i,
  input  logic                         mode_i,   // 0: thermometer, 1: rotation
  output logic [(2**OUTPUT_WIDTH)-1:0] elem_o,
  output logic                         valid_o,
  output logic [OUTPUT_WIDTH-1:0]      ptr_o,
  output logic [OUTPUT_WIDTH-1:0]      ones_o,
  output logic                         wrap_o
);

  localparam int unsigned NUM_ELEM = 2 ** OUTPUT_WIDTH;

  logic [NUM_ELEM-1:0]     elem_d, elem_q;
  logic                    valid_d, valid_q;
  logic [OUTPUT_WIDTH-1:0] ptr_d, ptr_q;
  logic [OUTPUT_WIDTH-1:0] ones_d, ones_q;
  logic                    wrap_d, wrap_q;

  // One extra bit so the carry out of the pointer add marks a wrap.
  logic [OUTPUT_WIDTH:0]   ptr_sum;
  logic [OUTPUT_WIDTH-1:0] rot_off;
  logic [NUM_ELEM-1:0]     therm;
  logic [NUM_ELEM-1:0]     rot;

  // Element patterns and next-state selection for the sample on the inputs.
  always_comb begin
    elem_d  = elem_q;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    ones_d  = ones_q;
    wrap_d  = 1'b0;
    rot_off = '0;
    therm   = '0;
    rot     = '0;

    ptr_sum = {1'b0, ptr_q} + {1'b0, code_i};

    for (int k = 0; k < NUM_ELEM; k++) begin
      therm[k] = OUTPUT_WIDTH'(k) < code_i;
      // Distance of element k past the pointer, modulo NUM_ELEM.
      rot_off  = OUTPUT_WIDTH'(k) - ptr_q;
      rot[k]   = rot_off < code_i;
    end

    if (valid_i) begin
      valid_d = 1'b1;
      ones_d  = code_i;
      if (mode_i) begin
        elem_d = rot;
        ptr_d  = ptr_sum[OUTPUT_WIDTH-1:0];
        wrap_d = ptr_sum[OUTPUT_WIDTH];
      end else begin
        elem_d = therm;
      end
    end
  end

  // Output and pointer registers; reset wins over a concurrent sample.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      elem_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      ones_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      elem_q  <= elem_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      ones_q  <= ones_d;
      wrap_q  <= wrap_d;
    end
  end

  assign elem_o  = elem_q;
  assign valid_o = valid_q;
  assign ptr_o   = ptr_q;
  assign ones_o  = ones_q;
  assign wrap_o  = wrap_q;

endmodule

// File: doc/dwa_selector.md
DWA_SELECTOR -- requirements
Module: dwa_selector

Interface
REQ-001 SHALL take parameter OUTPUT_WIDTH, default 3 (from lib_switchblock_pkg), width of quantizer code input.
REQ-002 SHALL derive localparam NUM_ELEM = 2**OUTPUT_WIDTH, default 8, number of unit DAC elements.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 code_i  input  OUTPUT_WIDTH  unsigned quantizer code = number of elements to enable (0..NUM_ELEM-1).
REQ-006 valid_i  input  1  code_i valid this cycle.
REQ-007 mode_i  input  1  0 = static thermometer, 1 = data-weighted averaging (DWA) rotation.
REQ-008 elem_o  output  NUM_ELEM  unit element enables; bit k drives element k.
REQ-009 valid_o  output  1  elem_o updated this cycle.
REQ-010 ptr_o  output  OUTPUT_WIDTH  current rotation pointer (next start element).
REQ-011 ones_o  output  OUTPUT_WIDTH  population count of elem_o.
REQ-012 wrap_o  output  1  one-cycle pulse: the rotation pointer wrapped past element NUM_ELEM-1.

Function
REQ-013 All outputs SHALL be registered; latency code_i -> elem_o is exactly 1 cycle.
REQ-014 Valid sample, mode_i=1: elem_o bits (ptr+j) mod NUM_ELEM for j=0..code_i-1 set, all others 0.
REQ-015 Valid sample, mode_i=1: ptr SHALL update to (ptr+code_i) mod NUM_ELEM in the same edge; the new value is visible on ptr_o with elem_o.
REQ-016 wrap_o SHALL be 1 in the output cycle iff mode_i=1 and ptr+code_i >= NUM_ELEM (unsigned, OUTPUT_WIDTH+1 bit sum); else 0.
REQ-017 Valid sample, mode_i=0: elem_o = thermometer bits 0..code_i-1 set; ptr held; wrap_o=0.
REQ-018 code_i=0: elem_o all zero, ptr unchanged, wrap_o=0, valid_o=1.
REQ-019 ones_o SHALL equal code_i of the accepted sample in every mode.
REQ-020 valid_i=0: valid_o=0, wrap_o=0; elem_o, ones_o, ptr held at previous values (DAC holds last level).
REQ-021 mode_i is sampled per valid sample only; a mode change takes effect on the next valid sample, ptr is not reset by a mode change.
REQ-022 Back-to-back valid samples SHALL be accepted every cycle without stall; no back-pressure exists.
REQ-023 Pointer arithmetic SHALL be modulo NUM_ELEM with no saturation; codes are never clipped.

Reset
REQ-024 When rst_i=0 at a rising edge: elem_o=0, valid_o=0, ptr_o=0, ones_o=0, wrap_o=0.
REQ-025 Reset SHALL take priority over valid_i in the same cycle; the concurrent sample is discarded.
REQ-026 First valid sample after rst_i returns to 1 SHALL start at element 0.

Verification
REQ-027 Reset, mode=1, codes 3,6,7 consecutive -> elem_o 0000_0111 (ptr 3, wrap 0), 1111_1001 (ptr 1, wrap 1), 1111_1110 (ptr 0, wrap 1).
REQ-028 mode=0, codes 5 then 2 -> elem_o 0001_1111 then 0000_0011, ptr_o stays 0, wrap_o 0, ones_o 5 then 2.
REQ-029 mode=1, code 4 then valid_i=0 for 3 cycles then code 1 -> elem_o 0000_1111 held 3 cycles with valid_o=0, then 0001_0000, ptr 5.
REQ-030 mode=1, code 0 at ptr=3 -> elem_o 0000_0000, ptr_o 3, valid_o 1, wrap_o 0.
REQ-031 Mid-stream rst_i=0 for 1 cycle with valid_i=1, code 7 -> all outputs 0; next code 2 -> elem_o 0000_0011, ptr 2.
REQ-032 Random codes, 1000 samples, mode=1 -> every element usage count within 1 of every other after each full pointer wrap; ones_o equals code_i each valid cycle.
